instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encodes instruction fields into 32-bit ARM-style words and writes them sequentially into instruction memory, one word per handshake.
- It is the inverse of the control-unit instruction decoder: words it emits decode back to the same Op/Funct/Rd/IsMul values.
- Used by test harnesses and boot logic to preload programs ahead of the multicycle core.

Parameters:
ADDR_W, 32, width of mem_addr (byte address).
BASE_ADDR, 0, byte address of the first word written after reset or start.
DEPTH, 64, maximum number of words per load session.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  pulse; begins a new load session (honoured only in IDLE/DONE).
in_valid  input  1  field bundle valid.
in_ready  output  1  encoder can accept a bundle.
in_kind  input  3  0 DP_REG, 1 DP_IMM, 2 MEM, 3 BRANCH, 4 MUL, 5 UMULL, 6 SMULL, 7 illegal.
in_cond  input  4  condition field, bits 31:28.
in_cmd  input  4  DP cmd (bits 24:21); in_cmd[0] = L for MEM (load) and BRANCH (link).
in_s  input  1  S bit for DP and multiplies.
in_rd  input  4  Rd; RdLo for long multiplies.
in_rn  input  4  Rn; RdHi for long multiplies.
in_rm  input  4  Rm.
in_rs  input  4  Rs for multiplies.
in_imm  input  24  immediate: [11:0] for DP_IMM/MEM, [23:0] for BRANCH.
in_last  input  1  this bundle is the final word of the session.
mem_we  output  1  instruction-memory write strobe.
mem_addr  output  ADDR_W  write byte address.
mem_wdata  output  32  encoded word.
done  output  1  session finished.
err  output  1  sticky illegal-kind flag.
word_count  output  clog2(DEPTH)+1  number of words written this session.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err=0, word_count=0.
- FSM states: IDLE, ENC, WR, DONE.
- IDLE
  - in_ready=1.
  - in_valid at an edge: capture the fields, go to ENC.
  - start in IDLE: mem_addr=BASE_ADDR, word_count=0, err=0. start has priority over in_valid in the same cycle; the bundle is not accepted.
- ENC
  - in_ready=0.
  - Register mem_wdata, go to WR.
  - Illegal kind: set err, skip the write, go to IDLE (or DONE if in_last).
- WR
  - mem_we=1 for exactly one cycle; the write commits at the edge that leaves WR.
  - At that edge: mem_addr += 4, word_count += 1.
  - Go to DONE if in_last or word_count reaches DEPTH; otherwise go to IDLE.
- DONE
  - done=1, in_ready=0.
  - start: clear counters and err, go to IDLE.
- Timing: accept at edge k; mem_we is high between edges k+1 and k+2. Throughput is one word per 3 cycles.
- start in ENC/WR is ignored.
- Encoding (bits 31:28 = in_cond for every kind):
  - DP_REG: [27:26]=00, [25]=0, [24:21]=cmd, [20]=S, [19:16]=Rn, [15:12]=Rd, [11:4]=0, [3:0]=Rm.
  - DP_IMM: as DP_REG but [25]=1 and [11:0]=in_imm[11:0].
  - MEM: [27:20]={01,0,1,1,0,0,L}, Rn, Rd, [11:0]=in_imm[11:0].
  - BRANCH: [27:25]=101, [24]=L, [23:0]=in_imm.
  - MUL: [27:21]=0000000, [20]=S, [19:16]=Rd, [15:12]=0, [11:8]=Rs, [7:4]=1001, [3:0]=Rm.
  - UMULL: [27:21]=0000100, [20]=S, [19:16]=RdHi(in_rn), [15:12]=RdLo(in_rd), Rs, 1001, Rm.
  - SMULL: as UMULL with [27:21]=0000110.
- Address wrap: DEPTH bounds the session, so mem_addr never exceeds BASE_ADDR + 4*(DEPTH-1) on a write.
- Reset mid-session: any pending write is dropped and no mem_we is issued.

Optional Feature:
- ENC_CMP_FORCE_S_EN defined: DP_REG/DP_IMM with cmd 1010 (CMP) always encodes S=1, regardless of in_s.
- Undefined: in_s passes through unchanged.

Test Plan:
- DP_REG cond E, cmd 0100, S0, rd1, rn2, rm3 -> mem_we once, mem_addr 0x0, mem_wdata 0xE0821003, word_count 1.
- DP_IMM cond E, cmd 0010, S1, rd0, rn0, imm 0x001 -> 0xE2500001. Then MEM L=1, rd1, rn2, imm 8 -> 0xE5921008 at addr 0x4.
- MUL rd4, rs6, rm5 -> 0xE0040695. UMULL rd2, rn3, rs5, rm4 -> 0xE0832594. SMULL with the same fields -> 0xE0C32594.
- BRANCH cond 0, L0, imm 0x000010 -> 0x0A000010. in_last=1 -> done=1 and in_ready=0; start -> addr 0x0, count 0, in_ready=1.
- DEPTH=4, four bundles with in_last=0 -> addresses 0,4,8,C; done after the 4th; a 5th in_valid is not accepted.
- in_kind=7 -> err=1, no mem_we, mem_addr unchanged. reset low during WR -> no write, all outputs at reset values.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus for instr_encoder_loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [3:0]        in_cond;
  logic [3:0]        in_cmd;
  logic              in_s;
  logic [3:0]        in_rd;
  logic [3:0]        in_rn;
  logic [3:0]        in_rm;
  logic [3:0]        in_rs;
  logic [23:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_kind, in_cond, in_cmd, in_s, in_rd, in_rn, in_rm, in_rs, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_cond, in_cmd, in_s, in_rd, in_rn, in_rm, in_rs, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes ARM-style instruction field bundles and writes them sequentially into instruction memory.
// Optional macro ENC_CMP_FORCE_S_EN: DP CMP (cmd 1010) always encodes S=1.
module instr_encoder_loader #(
  parameter int          ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          DEPTH     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  instr_encoder_loader_if.slave    bus,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   word_count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [2:0] K_DP_REG = 3'd0;
  localparam logic [2:0] K_DP_IMM = 3'd1;
  localparam logic [2:0] K_MEM    = 3'd2;
  localparam logic [2:0] K_BR     = 3'd3;
  localparam logic [2:0] K_MUL    = 3'd4;
  localparam logic [2:0] K_UMULL  = 3'd5;
  localparam logic [2:0] K_SMULL  = 3'd6;
  localparam logic [2:0] K_ILL    = 3'd7;

  typedef enum logic [1:0] {IDLE, ENC, WR, DONE} state_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [23:0] imm;
    logic        last;
  } req_t;

  state_t state;
  req_t   req;

  function automatic logic [31:0] encode(input req_t r);
    logic s;
    s = r.s;
`ifdef ENC_CMP_FORCE_S_EN
    if ((r.kind == K_DP_REG || r.kind == K_DP_IMM) && r.cmd == 4'b1010) s = 1'b1;
`endif
    case (r.kind)
      K_DP_REG: encode = {r.cond, 2'b00, 1'b0, r.cmd, s, r.rn, r.rd, 8'h00, r.rm};
      K_DP_IMM: encode = {r.cond, 2'b00, 1'b1, r.cmd, s, r.rn, r.rd, r.imm[11:0]};
      K_MEM:    encode = {r.cond, 7'b0101100, r.cmd[0], r.rn, r.rd, r.imm[11:0]};
      K_BR:     encode = {r.cond, 3'b101, r.cmd[0], r.imm};
      K_MUL:    encode = {r.cond, 7'b0000000, s, r.rd, 4'h0, r.rs, 4'b1001, r.rm};
      K_UMULL:  encode = {r.cond, 7'b0000100, s, r.rn, r.rd, r.rs, 4'b1001, r.rm};
      K_SMULL:  encode = {r.cond, 7'b0000110, s, r.rn, r.rd, r.rs, 4'b1001, r.rm};
      default:  encode = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req           <= '0;
      bus.in_ready  <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE;
      bus.mem_wdata <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      word_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start wins over a same-cycle bundle; the bundle is dropped
          if (start) begin
            bus.mem_addr <= BASE;
            word_count   <= '0;
            err          <= 1'b0;
          end else if (bus.in_valid) begin
            req          <= '{bus.in_kind, bus.in_cond, bus.in_cmd, bus.in_s, bus.in_rd,
                              bus.in_rn, bus.in_rm, bus.in_rs, bus.in_imm, bus.in_last};
            bus.in_ready <= 1'b0;
            state        <= ENC;
          end
        end
        ENC: begin
          if (req.kind == K_ILL) begin
            err <= 1'b1;
            if (req.last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= IDLE;
            end
          end else begin
            bus.mem_wdata <= encode(req);
            bus.mem_we    <= 1'b1;
            state         <= WR;
          end
        end
        WR: begin
          bus.mem_we   <= 1'b0;
          bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
          word_count   <= word_count + CNT_W'(1);
          // session is capped at DEPTH words so the address never runs past the window
          if (req.last || word_count == CNT_W'(DEPTH - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            bus.in_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        DONE: begin
          if (start) begin
            bus.mem_addr <= BASE;
            word_count   <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            bus.in_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
